// File: rtl/mdu_scheduler.sv
// mdu_scheduler: multiply/divide unit scheduler with HI/LO register pair.
//
// Accepts mult/multu/div/divu from the E stage when idle, computes the result
// into a pending HI/LO pair on the accept edge, holds busy for MULT_CYCLES or
// DIV_CYCLES cycles, then commits pending HI/LO on the final busy edge.
// mthi/mtlo write HI/LO directly while idle.
//
// Optional feature macro: MDU_CANCEL_EN (adds md_cancel input).
//
// Ports:
//   clk        - clock, rising edge
//   reset      - asynchronous active-low reset
//   md_cancel  - (MDU_CANCEL_EN only) abort in-flight op / suppress accept
//   E_mdop     - E-stage op code (001 mult, 010 multu, 011 div, 100 divu,
//                101 mthi, 110 mtlo, others none)
//   E_rs       - first operand / mthi-mtlo source
//   E_rt       - second operand
//   E_rdsel    - read select for E_md_out (1 HI, 0 LO)
//   D_md_use   - D-stage instruction uses the MDU
//   E_md_out   - committed HI or LO value (combinational)
//   start      - multi-cycle op accepted this cycle (combinational)
//   busy       - multi-cycle op in flight (state decode)
//   D_md_stall - D-stage stall request (combinational)
module mdu_scheduler #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
`ifdef MDU_CANCEL_EN
  input  logic        md_cancel,
`endif
  input  logic [2:0]  E_mdop,
  input  logic [31:0] E_rs,
  input  logic [31:0] E_rt,
  input  logic        E_rdsel,
  input  logic        D_md_use,
  output logic [31:0] E_md_out,
  output logic        start,
  output logic        busy,
  output logic        D_md_stall
);

  localparam int unsigned MAX_N = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W = (MAX_N > 1) ? $clog2(MAX_N) : 1;

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        hi_q, hi_d, lo_q, lo_d;
  logic [31:0]        pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic               pend_wr_q, pend_wr_d;

  logic               cancel;
  logic               op_valid;
  logic               is_mul;

`ifdef MDU_CANCEL_EN
  assign cancel = md_cancel;
`else
  assign cancel = 1'b0;
`endif

  // Request decode and externally visible handshake
  assign op_valid   = (E_mdop == OP_MULT) || (E_mdop == OP_MULTU) ||
                      (E_mdop == OP_DIV)  || (E_mdop == OP_DIVU);
  assign is_mul     = (E_mdop == OP_MULT) || (E_mdop == OP_MULTU);
  // Gated by reset so start stays low while reset is asserted
  assign start      = reset && (state_q == IDLE) && op_valid && !cancel;
  assign busy       = (state_q != IDLE);
  assign D_md_stall = D_md_use && (start || busy);
  assign E_md_out   = E_rdsel ? hi_q : lo_q;

  // Arithmetic: 64-bit product and sign-magnitude division
  logic [63:0] mul_a, mul_b, prod;
  logic        div_signed, neg_a, neg_b;
  logic [31:0] mag_a, mag_b, divisor, q_mag, r_mag, quot, rem;

  always_comb begin
    mul_a      = (E_mdop == OP_MULT) ? {{32{E_rs[31]}}, E_rs} : {32'b0, E_rs};
    mul_b      = (E_mdop == OP_MULT) ? {{32{E_rt[31]}}, E_rt} : {32'b0, E_rt};
    prod       = mul_a * mul_b;

    div_signed = (E_mdop == OP_DIV);
    neg_a      = div_signed && E_rs[31];
    neg_b      = div_signed && E_rt[31];
    mag_a      = neg_a ? (32'd0 - E_rs) : E_rs;
    mag_b      = neg_b ? (32'd0 - E_rt) : E_rt;
    // Divide-by-zero result is discarded; substitute 1 to keep the divider defined
    divisor    = (E_rt == 32'd0) ? 32'd1 : mag_b;
    q_mag      = mag_a / divisor;
    r_mag      = mag_a % divisor;
    quot       = (neg_a ^ neg_b) ? (32'd0 - q_mag) : q_mag;
    rem        = neg_a ? (32'd0 - r_mag) : r_mag;
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          pend_hi_d = is_mul ? prod[63:32] : rem;
          pend_lo_d = is_mul ? prod[31:0]  : quot;
          pend_wr_d = is_mul || (E_rt != 32'd0);
          state_d   = is_mul ? MUL : DIV;
          cnt_d     = is_mul ? CNT_W'(MULT_CYCLES - 1) : CNT_W'(DIV_CYCLES - 1);
        end else if (E_mdop == OP_MTHI) begin
          hi_d = E_rs;
        end else if (E_mdop == OP_MTLO) begin
          lo_d = E_rs;
        end
      end
      MUL, DIV: begin
        if (cancel) begin
          state_d   = IDLE;
          cnt_d     = '0;
          pend_wr_d = 1'b0;
        end else if (cnt_q == '0) begin
          state_d   = IDLE;
          pend_wr_d = 1'b0;
          if (pend_wr_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_wr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
    end
  end

endmodule

// File: tb/tb_mdu_scheduler.sv
// tb_mdu_scheduler: directed self-checking bench for mdu_scheduler
// (default parameters: MULT_CYCLES=5, DIV_CYCLES=10).
module tb_mdu_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  E_mdop;
  logic [31:0] E_rs, E_rt;
  logic        E_rdsel, D_md_use;
  logic [31:0] E_md_out;
  logic        start, busy, D_md_stall;
`ifdef MDU_CANCEL_EN
  logic        md_cancel;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mdu_scheduler dut (
    .clk        (clk),
    .reset      (reset),
`ifdef MDU_CANCEL_EN
    .md_cancel  (md_cancel),
`endif
    .E_mdop     (E_mdop),
    .E_rs       (E_rs),
    .E_rt       (E_rt),
    .E_rdsel    (E_rdsel),
    .D_md_use   (D_md_use),
    .E_md_out   (E_md_out),
    .start      (start),
    .busy       (busy),
    .D_md_stall (D_md_stall)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs sample 1ns later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_hilo(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    E_rdsel = 1'b1;
    #1;
    check({tag, "_hi"}, E_md_out, exp_hi);
    E_rdsel = 1'b0;
    #1;
    check({tag, "_lo"}, E_md_out, exp_lo);
  endtask

  task automatic run_busy(input string tag, input int n, input logic exp_stall);
    for (int i = 0; i < n; i++) begin
      check({tag, "_busy"}, 32'(busy), 32'd1);
      check({tag, "_start_low"}, 32'(start), 32'd0);
      if (exp_stall) check({tag, "_stall"}, 32'(D_md_stall), 32'd1);
      tick();
    end
    check({tag, "_done"}, 32'(busy), 32'd0);
  endtask

  initial begin
    reset    = 1'b0;
    E_mdop   = 3'b000;
    E_rs     = '0;
    E_rt     = '0;
    E_rdsel  = 1'b0;
    D_md_use = 1'b0;
`ifdef MDU_CANCEL_EN
    md_cancel = 1'b0;
`endif

    // Reset state, including start forced low with a valid op presented
    tick();
    E_mdop = 3'b001;
    D_md_use = 1'b1;
    #1;
    check("rst_start", 32'(start), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_stall", 32'(D_md_stall), 32'd0);
    check_hilo("rst", 32'h0, 32'h0);
    tick();
    E_mdop = 3'b000;
    D_md_use = 1'b0;
    reset = 1'b1;
    tick();

    // mult -1 * 2
    E_mdop = 3'b001; E_rs = 32'hFFFF_FFFF; E_rt = 32'd2;
    #1;
    check("mult_start", 32'(start), 32'd1);
    check("mult_idle", 32'(busy), 32'd0);
    tick();
    E_mdop = 3'b000;
    #1;
    check("mult_pending_hidden", E_md_out, 32'h0);
    run_busy("mult", 5, 1'b0);
    check_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFE);

    // multu back-to-back; ops presented while busy must be ignored
    E_mdop = 3'b010;
    #1;
    check("multu_start", 32'(start), 32'd1);
    tick();
    E_mdop = 3'b110; E_rs = 32'hDEAD_BEEF;
    #1;
    check("multu_ign_mtlo_start", 32'(start), 32'd0);
    check("multu_b1", 32'(busy), 32'd1);
    tick();
    E_mdop = 3'b011;
    #1;
    check("multu_ign_div_start", 32'(start), 32'd0);
    check("multu_b2", 32'(busy), 32'd1);
    tick();
    E_mdop = 3'b000;
    run_busy("multu", 3, 1'b0);
    check_hilo("multu", 32'h0000_0001, 32'hFFFF_FFFE);

    // div -7 / 2 with D-stage stall
    E_mdop = 3'b011; E_rs = 32'hFFFF_FFF9; E_rt = 32'd2; D_md_use = 1'b1;
    #1;
    check("div_start", 32'(start), 32'd1);
    check("div_stall_accept", 32'(D_md_stall), 32'd1);
    tick();
    E_mdop = 3'b000;
    run_busy("div", 10, 1'b1);
    check("div_stall_clear", 32'(D_md_stall), 32'd0);
    check_hilo("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    D_md_use = 1'b0;

    // div overflow case
    E_mdop = 3'b011; E_rs = 32'h8000_0000; E_rt = 32'hFFFF_FFFF;
    tick();
    E_mdop = 3'b000;
    run_busy("div_ovf", 10, 1'b0);
    check_hilo("div_ovf", 32'h0, 32'h8000_0000);

    // div 7 / -2
    E_mdop = 3'b011; E_rs = 32'd7; E_rt = 32'hFFFF_FFFE;
    tick();
    E_mdop = 3'b000;
    run_busy("div_negb", 10, 1'b0);
    check_hilo("div_negb", 32'h1, 32'hFFFF_FFFD);

    // mtlo / mthi then divu by zero keeps HI/LO
    E_mdop = 3'b110; E_rs = 32'h1234;
    tick();
    check_hilo("mtlo", 32'h1, 32'h1234);
    E_mdop = 3'b101; E_rs = 32'hABCD;
    tick();
    check_hilo("mthi", 32'hABCD, 32'h1234);
    E_mdop = 3'b100; E_rs = 32'd5; E_rt = 32'd0;
    #1;
    check("divu0_start", 32'(start), 32'd1);
    tick();
    E_mdop = 3'b000;
    run_busy("divu0", 10, 1'b0);
    check_hilo("divu0", 32'hABCD, 32'h1234);

    // divu 100 / 7
    E_mdop = 3'b100; E_rs = 32'd100; E_rt = 32'd7;
    tick();
    E_mdop = 3'b000;
    run_busy("divu", 10, 1'b0);
    check_hilo("divu", 32'd2, 32'd14);

`ifdef MDU_CANCEL_EN
    // Cancel in busy cycle 2 of div keeps prior HI/LO
    E_mdop = 3'b110; E_rs = 32'h55;
    tick();
    E_mdop = 3'b101; E_rs = 32'h66;
    tick();
    E_mdop = 3'b011; E_rs = 32'd20; E_rt = 32'd3;
    tick();
    E_mdop = 3'b000;
    check("cancel_b1", 32'(busy), 32'd1);
    tick();
    md_cancel = 1'b1;
    #1;
    check("cancel_b2", 32'(busy), 32'd1);
    tick();
    md_cancel = 1'b0;
    check("cancel_idle", 32'(busy), 32'd0);
    for (int i = 0; i < 12; i++) tick();
    check("cancel_stay_idle", 32'(busy), 32'd0);
    check_hilo("cancel", 32'h66, 32'h55);
    // Cancel suppresses an accept in the same cycle
    md_cancel = 1'b1; E_mdop = 3'b001;
    #1;
    check("cancel_no_start", 32'(start), 32'd0);
    tick();
    md_cancel = 1'b0; E_mdop = 3'b000;
    check("cancel_no_accept", 32'(busy), 32'd0);
`endif

    // Reset in busy cycle 3 of a mult discards the op
    E_mdop = 3'b001; E_rs = 32'd3; E_rt = 32'd4;
    tick();
    E_mdop = 3'b000;
    tick();
    tick();
    check("rstmid_b3", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    check("rstmid_busy", 32'(busy), 32'd0);
    check_hilo("rstmid", 32'h0, 32'h0);
    tick();
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("rstmid_no_busy", 32'(busy), 32'd0);
      tick();
    end
    check_hilo("rstmid_after", 32'h0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdu_scheduler.md
MDU_SCHEDULER -- requirements
Module: mdu_scheduler

Interface
REQ-001 SHALL provide parameter MULT_CYCLES, default 5: busy cycles for mult/multu.
REQ-002 SHALL provide parameter DIV_CYCLES, default 10: busy cycles for div/divu.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port E_mdop  input  3  E-stage op: 000 none, 001 mult, 010 multu, 011 div, 100 divu, 101 mthi, 110 mtlo, 111 none.
REQ-006 SHALL have port E_rs  input  32  first operand; mthi/mtlo source.
REQ-007 SHALL have port E_rt  input  32  second operand.
REQ-008 SHALL have port E_rdsel  input  1  mfhi/mflo read select: 1 HI, 0 LO.
REQ-009 SHALL have port D_md_use  input  1  D-stage instruction is any mult/div/mfhi/mflo/mthi/mtlo.
REQ-010 SHALL have port E_md_out  output  32  selected HI or LO register value.
REQ-011 SHALL have port start  output  1  E_mdop multi-cycle op accepted this cycle.
REQ-012 SHALL have port busy  output  1  multi-cycle op in flight.
REQ-013 SHALL have port D_md_stall  output  1  D-stage stall request.

Function
REQ-014 SHALL implement FSM states IDLE, MUL, DIV with a down-counter; transitions occur only from IDLE.
REQ-015 SHALL assert start combinationally when E_mdop is in 001..100 and state is IDLE.
REQ-016 SHALL compute the result on the accept edge into pending HI/LO, then go MUL or DIV with the counter loaded to N-1, where N is MULT_CYCLES or DIV_CYCLES.
REQ-017 SHALL hold busy=1 for exactly N cycles after the accept cycle, then return to IDLE on the edge where the counter reaches 0.
REQ-018 SHALL commit pending HI/LO on that same final edge, so E_md_out reflects the new value N+1 cycles after the accept cycle.
REQ-019 SHALL, for mult, use signed 64-bit product and for multu unsigned: HI=[63:32], LO=[31:0].
REQ-020 SHALL, for div, produce a quotient truncated toward zero in LO and a remainder with the dividend's sign in HI; divu is unsigned.
REQ-021 SHALL handle div 0x80000000/0xFFFFFFFF as LO=0x80000000, HI=0.
REQ-022 SHALL, on a divisor of 0, run the full DIV_CYCLES busy period with HI/LO unchanged.
REQ-023 SHALL write E_rs to HI (mthi) or LO (mtlo) on the rising edge when IDLE.
REQ-024 SHALL ignore any E_mdop received while busy=1 (no state change).
REQ-025 SHALL drive D_md_stall = D_md_use & (start | busy).
REQ-026 SHALL make E_md_out combinational from committed HI/LO only; pending values are never visible.
REQ-027 SHALL accept a new op on the first IDLE cycle after completion; back-to-back ops have no gap beyond the busy period.

Reset
REQ-028 SHALL, while reset=0, force state IDLE, counter 0, HI=LO=0, pending=0, start=busy=D_md_stall=0 regardless of clk.
REQ-029 SHALL discard an in-flight op on reset, leaving no commit after release.

Configuration
REQ-030 SHALL recognise the macro MDU_CANCEL_EN.
REQ-031 SHALL, when MDU_CANCEL_EN is defined, add input port md_cancel (1 bit). md_cancel=1 while busy returns the FSM to IDLE on the next edge with HI/LO unchanged, and md_cancel=1 suppresses an accept in the same cycle.
REQ-032 SHALL, when MDU_CANCEL_EN is undefined, omit md_cancel, and every accepted op SHALL complete.

Verification
REQ-033 SHALL verify mult: E_rs=0xFFFFFFFF (-1), E_rt=2 -> start for 1 cycle, busy for 5 cycles, then HI=0xFFFFFFFF and LO=0xFFFFFFFE.
REQ-034 SHALL verify multu with the same operands -> HI=0x00000001, LO=0xFFFFFFFE after 5 busy cycles.
REQ-035 SHALL verify div: E_rs=-7, E_rt=2 -> busy for 10 cycles, then LO=0xFFFFFFFD (-3) and HI=0xFFFFFFFF (-1); D_md_use=1 during busy -> D_md_stall=1 for every busy cycle.
REQ-036 SHALL verify divu by 0 after mtlo 0x1234 -> busy for 10 cycles, then LO still 0x1234.
REQ-037 SHALL verify reset pulled low in busy cycle 3 of a mult -> busy=0 immediately, HI=LO=0 after release, and no later commit.
REQ-038 SHALL verify, with MDU_CANCEL_EN defined, md_cancel in busy cycle 2 of div -> IDLE next cycle and HI/LO keep their prior values.
